// File: rtl/rf_hazard_controller_pkg.sv
// Shared definitions for the register-file hazard controller: forwarding
// select codes, the PC register specifier, the shadow tag record, and the
// forwarding priority function used by all three read ports.
package rf_hazard_controller_pkg;

  localparam int unsigned REG_BITS = 4;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  localparam logic [REG_BITS-1:0] REG_PC = 4'd15;

  typedef struct packed {
    logic                valid;
    logic [REG_BITS-1:0] rd;
    logic                is_load;
  } tag_t;

  localparam tag_t TAG_NONE = '{valid: 1'b0, rd: '0, is_load: 1'b0};

  // Index 0 is EX (youngest), 1 is MEM, 2 is WB; the youngest match wins.
  // PC reads and unused ports always come from the register file.
  function automatic logic [1:0] fwd_sel(logic [2:0]               stage_valid,
                                         logic [2:0][REG_BITS-1:0] stage_rd,
                                         logic [REG_BITS-1:0]      src,
                                         logic                     use_port);
    logic [1:0] sel;
    sel = FWD_RF;
    if (use_port && (src != REG_PC)) begin
      if (stage_valid[0] && (stage_rd[0] == src)) begin
        sel = FWD_EX;
      end else if (stage_valid[1] && (stage_rd[1] == src)) begin
        sel = FWD_MEM;
      end else if (stage_valid[2] && (stage_rd[2] == src)) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/rf_hazard_controller_if.sv
// ID-stage hazard bus: decoded operand/destination info in, forwarding
// selects and pipeline control out. The decoder side is the master.
interface rf_hazard_controller_if #(
  parameter int unsigned NREG_BITS   = 4,
  parameter int unsigned STALL_CNT_W = 16
);

  logic                   ID_VALID;
  logic [NREG_BITS-1:0]   ID_SA;
  logic [NREG_BITS-1:0]   ID_SB;
  logic [NREG_BITS-1:0]   ID_SD;
  logic                   ID_USE_A;
  logic                   ID_USE_B;
  logic                   ID_USE_D;
  logic [NREG_BITS-1:0]   ID_C;
  logic                   ID_RFLD;
  logic                   ID_IS_LOAD;
  logic                   BRANCH_TAKEN;
  logic [1:0]             FWD_A;
  logic [1:0]             FWD_B;
  logic [1:0]             FWD_D;
  logic                   HZPCLD;
  logic                   IFID_LD;
  logic                   ID_BUBBLE;
  logic [STALL_CNT_W-1:0] STALL_CNT;

  modport master (
    output ID_VALID, ID_SA, ID_SB, ID_SD, ID_USE_A, ID_USE_B, ID_USE_D,
    output ID_C, ID_RFLD, ID_IS_LOAD, BRANCH_TAKEN,
    input  FWD_A, FWD_B, FWD_D, HZPCLD, IFID_LD, ID_BUBBLE, STALL_CNT
  );

  modport slave (
    input  ID_VALID, ID_SA, ID_SB, ID_SD, ID_USE_A, ID_USE_B, ID_USE_D,
    input  ID_C, ID_RFLD, ID_IS_LOAD, BRANCH_TAKEN,
    output FWD_A, FWD_B, FWD_D, HZPCLD, IFID_LD, ID_BUBBLE, STALL_CNT
  );

endinterface

// File: rtl/rf_hazard_controller_hz_tag_stage.sv
// One stage of the shadow destination-tag pipeline. A bubble loads an
// invalid tag in place of the incoming one.
module hz_tag_stage
  import rf_hazard_controller_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic bubble,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t tag_q;

  // Tag register: reset and bubble both leave the stage empty.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tag_q <= TAG_NONE;
    end else if (bubble) begin
      tag_q <= TAG_NONE;
    end else begin
      tag_q <= tag_in;
    end
  end

  assign tag_out = tag_q;

endmodule

// File: rtl/rf_hazard_controller.sv
// ID-stage hazard controller: tracks in-flight destinations (EX/MEM/WB),
// selects operand forwarding for ports A/B/D, stalls on load-use and
// squashes the ID instruction on a taken branch.
module rf_hazard_controller
  import rf_hazard_controller_pkg::*;
#(
  parameter int unsigned NREG_BITS   = 4,
  parameter int unsigned STALL_CNT_W = 16
) (
  input logic                  CLK,
  input logic                  RST,
  rf_hazard_controller_if.slave hz
);

  logic [NREG_BITS-1:0]     src_a, src_b, src_d, dst_c;
  tag_t                     id_tag, ex_tag, mem_tag, wb_tag;
  logic [2:0]               stage_valid;
  logic [2:0][REG_BITS-1:0] stage_rd;
  logic [1:0]               sel_a, sel_b, sel_d;
  logic                     load_use;
  logic                     pc_ld, ifid_ld, bubble;
  logic [STALL_CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  assign src_a = hz.ID_SA;
  assign src_b = hz.ID_SB;
  assign src_d = hz.ID_SD;
  assign dst_c = hz.ID_C;

  // ID destination tag; PC writes go through the PC path and are never tracked.
  always_comb begin
    id_tag         = TAG_NONE;
    id_tag.valid   = hz.ID_VALID && hz.ID_RFLD && (dst_c != REG_PC);
    id_tag.rd      = dst_c;
    id_tag.is_load = id_tag.valid && hz.ID_IS_LOAD;
  end

  hz_tag_stage u_ex (
    .CLK     (CLK),
    .RST     (RST),
    .bubble  (bubble),
    .tag_in  (id_tag),
    .tag_out (ex_tag)
  );

  hz_tag_stage u_mem (
    .CLK     (CLK),
    .RST     (RST),
    .bubble  (1'b0),
    .tag_in  (ex_tag),
    .tag_out (mem_tag)
  );

  hz_tag_stage u_wb (
    .CLK     (CLK),
    .RST     (RST),
    .bubble  (1'b0),
    .tag_in  (mem_tag),
    .tag_out (wb_tag)
  );

  // WB is the last tracked stage, so its load flag has no consumer.
  logic unused_wb_load;
  assign unused_wb_load = wb_tag.is_load;

  assign stage_valid = {wb_tag.valid, mem_tag.valid, ex_tag.valid};
  assign stage_rd    = {wb_tag.rd, mem_tag.rd, ex_tag.rd};

  // Per-port forwarding selects, youngest producer first.
  always_comb begin
    sel_a = fwd_sel(stage_valid, stage_rd, src_a, hz.ID_USE_A);
    sel_b = fwd_sel(stage_valid, stage_rd, src_b, hz.ID_USE_B);
    sel_d = fwd_sel(stage_valid, stage_rd, src_d, hz.ID_USE_D);
  end

  // A load in EX cannot forward yet; any port wanting it forces a stall.
  assign load_use = hz.ID_VALID && ex_tag.is_load &&
                    ((sel_a == FWD_EX) || (sel_b == FWD_EX) || (sel_d == FWD_EX));

  // Pipeline control: a stall beats a branch so the branch re-resolves with
  // the forwarded operand on the following cycle.
  always_comb begin
    pc_ld   = 1'b1;
    ifid_ld = 1'b1;
    bubble  = 1'b0;
    if (load_use) begin
      pc_ld   = 1'b0;
      ifid_ld = 1'b0;
      bubble  = 1'b1;
    end else if (hz.BRANCH_TAKEN) begin
      bubble  = 1'b1;
    end
  end

  // Saturating stall counter next state.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (load_use && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Stall counter register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.FWD_A     = sel_a;
  assign hz.FWD_B     = sel_b;
  assign hz.FWD_D     = sel_d;
  assign hz.HZPCLD    = pc_ld;
  assign hz.IFID_LD   = ifid_ld;
  assign hz.ID_BUBBLE = bubble;
  assign hz.STALL_CNT = stall_cnt_q;

endmodule

// File: tb/tb_rf_hazard_controller.sv
// Bench for rf_hazard_controller: directed scenarios plus randomized traffic
// checked against a history-of-issued-instructions reference model.
module tb_rf_hazard_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rf_hazard_controller_if #(.NREG_BITS(4), .STALL_CNT_W(16)) hz_bus ();

  rf_hazard_controller #(.NREG_BITS(4), .STALL_CNT_W(16)) dut (
    .CLK (clk),
    .RST (rst),
    .hz  (hz_bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: instructions that left ID, most recent first. Entry k
  // was issued k+1 cycles ago; only the last three can still need forwarding.
  typedef struct {
    bit valid;
    int rd;
    bit is_load;
  } issued_t;

  issued_t hist[$];
  int      exp_cnt;

  function automatic void model_reset();
    issued_t e;
    e.valid = 0; e.rd = 0; e.is_load = 0;
    hist.delete();
    for (int k = 0; k < 3; k++) hist.push_back(e);
    exp_cnt = 0;
  endfunction

  function automatic logic [1:0] model_sel(int src, bit used);
    if (!used || src == 15) return 2'd0;
    for (int age = 0; age < 3; age++)
      if (hist[age].valid && hist[age].rd == src) return 2'(age + 1);
    return 2'd0;
  endfunction

  function automatic bit reads_reg(int src, bit used, int r);
    return used && src != 15 && src == r;
  endfunction

  // Stall when the instruction issued one cycle ago is a load and a used
  // port reads its destination.
  function automatic bit model_hazard();
    int r;
    if (!hz_bus.ID_VALID || !hist[0].valid || !hist[0].is_load) return 0;
    r = hist[0].rd;
    return reads_reg(int'(hz_bus.ID_SA), hz_bus.ID_USE_A, r) ||
           reads_reg(int'(hz_bus.ID_SB), hz_bus.ID_USE_B, r) ||
           reads_reg(int'(hz_bus.ID_SD), hz_bus.ID_USE_D, r);
  endfunction

  // Advance one clock, updating the model from the inputs held before the edge.
  task automatic tick();
    bit      h, bub;
    issued_t e;
    h         = model_hazard();
    bub       = h || hz_bus.BRANCH_TAKEN;
    e.valid   = !bub && hz_bus.ID_VALID && hz_bus.ID_RFLD && hz_bus.ID_C != 4'd15;
    e.rd      = int'(hz_bus.ID_C);
    e.is_load = e.valid && hz_bus.ID_IS_LOAD;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      hist.push_front(e);
      void'(hist.pop_back());
      if (h && exp_cnt < 65535) exp_cnt++;
    end
    #1;
  endtask

  task automatic drive(bit v, int sa, bit ua, int sb, bit ub, int sd, bit ud,
                       int c, bit rfld, bit ld, bit br);
    hz_bus.ID_VALID     = v;
    hz_bus.ID_SA        = 4'(sa);
    hz_bus.ID_USE_A     = ua;
    hz_bus.ID_SB        = 4'(sb);
    hz_bus.ID_USE_B     = ub;
    hz_bus.ID_SD        = 4'(sd);
    hz_bus.ID_USE_D     = ud;
    hz_bus.ID_C         = 4'(c);
    hz_bus.ID_RFLD      = rfld;
    hz_bus.ID_IS_LOAD   = ld;
    hz_bus.BRANCH_TAKEN = br;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Issue a register-writing instruction with no source operands.
  task automatic issue(int c, bit ld);
    drive(1, 0, 0, 0, 0, 0, 0, c, 1, ld, 0);
    tick();
  endtask

  task automatic do_reset();
    rst = 1;
    idle();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    idle();
    tests++; if (hz_bus.FWD_A !== 2'b00 || hz_bus.FWD_B !== 2'b00 || hz_bus.FWD_D !== 2'b00) begin
      fails++; $display("FAIL reset_fwd: got %b/%b/%b want 00/00/00", hz_bus.FWD_A, hz_bus.FWD_B, hz_bus.FWD_D); end
    tests++; if ({hz_bus.HZPCLD, hz_bus.IFID_LD, hz_bus.ID_BUBBLE} !== 3'b110) begin
      fails++; $display("FAIL reset_ctrl: got %b want 110", {hz_bus.HZPCLD, hz_bus.IFID_LD, hz_bus.ID_BUBBLE}); end
    tests++; if (hz_bus.STALL_CNT !== 16'd0) begin
      fails++; $display("FAIL reset_cnt: got %0d want 0", hz_bus.STALL_CNT); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue(2, 0);
    drive(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tests++; if (hz_bus.FWD_A !== 2'b01 || hz_bus.HZPCLD !== 1'b1) begin
      fails++; $display("FAIL b2b_ex: got fwd=%b pcld=%b want 01/1", hz_bus.FWD_A, hz_bus.HZPCLD); end
    tick();
    drive(1, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0);
    tests++; if (hz_bus.FWD_B !== 2'b10) begin
      fails++; $display("FAIL b2b_mem: got %b want 10", hz_bus.FWD_B); end
    tick();
    tests++; if (hz_bus.FWD_B !== 2'b11) begin
      fails++; $display("FAIL b2b_wb: got %b want 11", hz_bus.FWD_B); end
    tick();
    tests++; if (hz_bus.FWD_B !== 2'b00) begin
      fails++; $display("FAIL b2b_rf: got %b want 00", hz_bus.FWD_B); end
  endtask

  task automatic test_load_use();
    do_reset();
    issue(5, 1);
    drive(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0);
    tests++; if ({hz_bus.HZPCLD, hz_bus.IFID_LD, hz_bus.ID_BUBBLE} !== 3'b001) begin
      fails++; $display("FAIL lu_stall: got %b want 001", {hz_bus.HZPCLD, hz_bus.IFID_LD, hz_bus.ID_BUBBLE}); end
    tick();
    tests++; if (hz_bus.FWD_B !== 2'b10 || hz_bus.HZPCLD !== 1'b1 || hz_bus.ID_BUBBLE !== 1'b0) begin
      fails++; $display("FAIL lu_after: got fwd=%b pcld=%b bub=%b want 10/1/0", hz_bus.FWD_B, hz_bus.HZPCLD, hz_bus.ID_BUBBLE); end
    tests++; if (hz_bus.STALL_CNT !== 16'd1) begin
      fails++; $display("FAIL lu_cnt: got %0d want 1", hz_bus.STALL_CNT); end
  endtask

  task automatic test_priority();
    do_reset();
    issue(7, 0);
    issue(7, 0);
    issue(7, 0);
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
    tests++; if (hz_bus.FWD_D !== 2'b01) begin
      fails++; $display("FAIL prio_d: got %b want 01", hz_bus.FWD_D); end
  endtask

  task automatic test_r15();
    do_reset();
    issue(15, 0);
    drive(1, 15, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tests++; if (hz_bus.FWD_A !== 2'b00 || hz_bus.HZPCLD !== 1'b1) begin
      fails++; $display("FAIL r15_alu: got fwd=%b pcld=%b want 00/1", hz_bus.FWD_A, hz_bus.HZPCLD); end
    tick();
    issue(15, 1);
    drive(1, 15, 1, 15, 1, 15, 1, 0, 0, 0, 0);
    tests++; if ({hz_bus.HZPCLD, hz_bus.IFID_LD, hz_bus.ID_BUBBLE} !== 3'b110 || hz_bus.FWD_A !== 2'b00) begin
      fails++; $display("FAIL r15_load: got ctrl=%b fwd=%b want 110/00", {hz_bus.HZPCLD, hz_bus.IFID_LD, hz_bus.ID_BUBBLE}, hz_bus.FWD_A); end
    tick();
    tests++; if (hz_bus.STALL_CNT !== 16'd0) begin
      fails++; $display("FAIL r15_cnt: got %0d want 0", hz_bus.STALL_CNT); end
  endtask

  task automatic test_branch_hazard();
    do_reset();
    issue(4, 1);
    // Branch reads R4 on A and also writes R9; hazard wins over the branch.
    drive(1, 4, 1, 0, 0, 0, 0, 9, 1, 0, 1);
    tests++; if ({hz_bus.HZPCLD, hz_bus.IFID_LD, hz_bus.ID_BUBBLE} !== 3'b001) begin
      fails++; $display("FAIL br_stall: got %b want 001", {hz_bus.HZPCLD, hz_bus.IFID_LD, hz_bus.ID_BUBBLE}); end
    tick();
    tests++; if ({hz_bus.HZPCLD, hz_bus.IFID_LD, hz_bus.ID_BUBBLE} !== 3'b111 || hz_bus.FWD_A !== 2'b10) begin
      fails++; $display("FAIL br_taken: got ctrl=%b fwd=%b want 111/10", {hz_bus.HZPCLD, hz_bus.IFID_LD, hz_bus.ID_BUBBLE}, hz_bus.FWD_A); end
    tick();
    // Squashed branch must not appear in EX; the load is now in WB.
    drive(1, 9, 1, 4, 1, 0, 0, 0, 0, 0, 0);
    tests++; if (hz_bus.FWD_A !== 2'b00 || hz_bus.FWD_B !== 2'b11) begin
      fails++; $display("FAIL br_squash: got a=%b b=%b want 00/11", hz_bus.FWD_A, hz_bus.FWD_B); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    issue(3, 1);
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    issue(3, 1);
    drive(1, 3, 1, 3, 1, 3, 1, 0, 0, 0, 0);
    tests++; if (hz_bus.HZPCLD !== 1'b0 || hz_bus.STALL_CNT !== 16'd1) begin
      fails++; $display("FAIL rms_pre: got pcld=%b cnt=%0d want 0/1", hz_bus.HZPCLD, hz_bus.STALL_CNT); end
    rst = 1;
    tick();
    rst = 0;
    #1;
    tests++; if (hz_bus.FWD_A !== 2'b00 || hz_bus.FWD_B !== 2'b00 || hz_bus.FWD_D !== 2'b00) begin
      fails++; $display("FAIL rms_fwd: got %b/%b/%b want 00/00/00", hz_bus.FWD_A, hz_bus.FWD_B, hz_bus.FWD_D); end
    tests++; if ({hz_bus.HZPCLD, hz_bus.IFID_LD, hz_bus.ID_BUBBLE} !== 3'b110 || hz_bus.STALL_CNT !== 16'd0) begin
      fails++; $display("FAIL rms_ctrl: got ctrl=%b cnt=%0d want 110/0", {hz_bus.HZPCLD, hz_bus.IFID_LD, hz_bus.ID_BUBBLE}, hz_bus.STALL_CNT); end
  endtask

  function automatic int rnd_reg();
    int r;
    r = int'($urandom_range(0, 4));
    return (r == 4) ? 15 : r;
  endfunction

  task automatic test_random();
    bit h;
    bit br;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      br  = ($urandom_range(0, 7) == 0);
      drive($urandom_range(0, 7) != 0, rnd_reg(), 1'($urandom), rnd_reg(), 1'($urandom),
            rnd_reg(), 1'($urandom), rnd_reg(), 1'($urandom), 1'($urandom), br);
      h = model_hazard();
      tests++; if ({hz_bus.HZPCLD, hz_bus.IFID_LD, hz_bus.ID_BUBBLE} !== {!h, !h, h || br}) begin
        fails++; $display("FAIL rnd_ctrl[%0d]: got %b want %b", i, {hz_bus.HZPCLD, hz_bus.IFID_LD, hz_bus.ID_BUBBLE}, {!h, !h, h || br}); end
      tests++; if (hz_bus.STALL_CNT !== 16'(exp_cnt)) begin
        fails++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, hz_bus.STALL_CNT, exp_cnt); end
      if (!h) begin
        tests++;
        if (hz_bus.FWD_A !== model_sel(int'(hz_bus.ID_SA), hz_bus.ID_USE_A) ||
            hz_bus.FWD_B !== model_sel(int'(hz_bus.ID_SB), hz_bus.ID_USE_B) ||
            hz_bus.FWD_D !== model_sel(int'(hz_bus.ID_SD), hz_bus.ID_USE_D)) begin
          fails++;
          $display("FAIL rnd_fwd[%0d]: got %b/%b/%b want %b/%b/%b", i, hz_bus.FWD_A, hz_bus.FWD_B,
                   hz_bus.FWD_D, model_sel(int'(hz_bus.ID_SA), hz_bus.ID_USE_A),
                   model_sel(int'(hz_bus.ID_SB), hz_bus.ID_USE_B),
                   model_sel(int'(hz_bus.ID_SD), hz_bus.ID_USE_D));
        end
      end
      tick();
    end
    rst = 0;
  endtask

  initial begin
    model_reset();
    idle();
    test_reset();
    test_back_to_back();
    test_load_use();
    test_priority();
    test_r15();
    test_branch_hazard();
    test_reset_mid_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, want finish before 1ms");
    $fatal(1, "timeout");
  end

endmodule
